bin_to_digits: RTL and testbench
================================

Name: bin_to_digits

Overview:
Sequential binary-to-decimal digit splitter (shift-add-3 / double-dabble).
- Converts an unsigned magnitude plus a sign flag into per-digit 4-bit codes for the existing seven-segment `display` decoders.
- Replaces the combinational `/1000`, `%100` style arithmetic in the top level. It is the inverse path of operand entry: keypad digits → binary, versus binary → display digits.
- Sits between the calculator/stopwatch result registers and the display decoders.

Parameters:
- WIDTH, 32, bit width of input magnitude.
- DIGITS, 4, number of output digits.
- MINUS_CODE, 10, digit code the display decoder renders as "-".
- BLANK_CODE, 11, digit code the display decoder renders as all segments off.
- LZ_BLANK, 0, 1 = replace leading zeros with BLANK_CODE (least significant digit is never blanked).

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, reset, synchronous and active-high.
- start, input, 1, request conversion of value/negative; sampled only in IDLE.
- value, input, WIDTH, unsigned magnitude to convert.
- negative, input, 1, 1 = show sign on most significant digit.
- busy, output, 1, conversion in progress.
- done, output, 1, one-cycle pulse when digits have been updated.
- overflow, output, 1, last result did not fit; held until next done.
- digits, output, 4*DIGITS, digit codes; [3:0] is least significant digit, [4*DIGITS-1:4*DIGITS-4] is most significant.

Behaviour:
- Reset (rst high at an edge): state=IDLE, busy=0, done=0, overflow=0, all digits=BLANK_CODE.
- rst has priority over everything. Reset mid-conversion aborts the conversion with no done pulse.
- Internal BCD accumulator holds NB=(WIDTH+2)/3 digits (11 for WIDTH=32), which is enough for any WIDTH-bit value.
- States and transitions:
  - IDLE: if start is high at edge k, latch value into the shift register, latch negative, clear the BCD accumulator, busy←1, go to SHIFT with counter=0.
  - SHIFT: one bit per edge. Every BCD nibble ≥5 gets +3, then {bcd, shreg} shifts left by 1. After WIDTH shifts (edges k+1..k+WIDTH) go to FORMAT.
  - FORMAT (edge k+WIDTH+1): write digits and overflow, busy←0, done←1, return to IDLE.
- done is high for exactly the one cycle after the FORMAT edge; deasserted at the next edge.
- Latency: start edge to done high = WIDTH+1 edges (33 for WIDTH=32). Throughput is one conversion per WIDTH+2 cycles.
- start while busy is ignored; it is not queued.
- start high in the same cycle done is high is accepted, because the block is already in IDLE.
- value and negative may change freely after the start edge.
- Format when negative=0:
  - Usable range is 0..10^DIGITS-1.
  - In range: digits = low DIGITS BCD nibbles, overflow=0.
  - Out of range: all digits=9, overflow=1.
- Format when negative=1:
  - MSD=MINUS_CODE; the lower DIGITS-1 digits carry the magnitude, range 0..10^(DIGITS-1)-1.
  - Out of range: lower digits all 9, overflow=1.
  - Negative zero is displayed as "-000".
- Leading-zero blanking (LZ_BLANK=1):
  - Zero digits above the highest nonzero digit become BLANK_CODE.
  - The sign digit is never blanked.
  - Value 0 shows only digit0=0.
  - Blanking is not applied when overflow=1.
- digits and overflow hold their values between conversions; they change only at the FORMAT edge or at reset.

Test Plan:
1. Reset, then start with value=1234, negative=0 → busy high for cycles 1..33, done pulse on cycle 34 only, digits={1,2,3,4}, overflow=0.
2. value=0, then value=9999, then value=10000 (negative=0) → {0,0,0,0} ov=0; {9,9,9,9} ov=0; {9,9,9,9} ov=1.
3. value=57, negative=1 → {10,0,5,7} ov=0. value=1000, negative=1 → {10,9,9,9} ov=1. With LZ_BLANK=1, value=57, negative=1 → {10,11,5,7}.
4. LZ_BLANK=1: value=5 → {11,11,11,5}; value=0 → {11,11,11,0}; value=0xFFFFFFFF → {9,9,9,9} ov=1 with no blanking.
5. Pulse start with 1234, pulse start again with 42 at cycle 10 → single done at cycle 34 showing {1,2,3,4}. Then start on the done cycle with 42 → second done 33 edges later showing {0,0,4,2}.
6. Start with 1234, assert rst at cycle 15 → busy=0, no done pulse, digits all 11. A fresh start afterwards converts normally.

Source files
------------

// File: rtl/bin_to_digits.sv
// bin_to_digits
// Sequential binary-to-decimal digit splitter using shift-add-3 (double dabble).
// A start pulse in IDLE latches an unsigned magnitude and a sign flag. The value
// is shifted into a BCD accumulator one bit per clock for WIDTH clocks. One
// FORMAT clock then writes the display digit codes, applying the sign, the
// overflow clamp and optional leading-zero blanking.
//
// Handshake: start is sampled only while busy is low. A start seen while busy
// is dropped and is not queued. done pulses for exactly one cycle once the
// digits have been updated. digits and overflow hold their values until the
// next done or reset.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, has priority over everything
//   start     conversion request (sampled in IDLE only)
//   value     unsigned magnitude, WIDTH bits
//   negative  1 = render MINUS_CODE on the most significant digit
//   busy      conversion in progress
//   done      one-cycle pulse after digits/overflow are written
//   overflow  last result did not fit the display
//   digits    4-bit codes, [3:0] least significant digit
//   dbg_state current FSM state (0 IDLE, 1 SHIFT, 2 FORMAT)
//
// The design assumes DIGITS <= (WIDTH+2)/3.
module bin_to_digits #(
   parameter int WIDTH      = 32,
   parameter int DIGITS     = 4,
   parameter int MINUS_CODE = 10,
   parameter int BLANK_CODE = 11,
   parameter int LZ_BLANK   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  negative,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   digits,
   output logic [1:0]            dbg_state
);

   // NB BCD nibbles are enough to hold any WIDTH-bit value.
   localparam int NB = (WIDTH + 2) / 3;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [3:0] BLANK4 = 4'(BLANK_CODE);
   localparam logic [3:0] MINUS4 = 4'(MINUS_CODE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FORMAT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WIDTH-1:0]    r_shreg;
   logic [4*NB-1:0]     r_bcd;
   logic [4*NB-1:0]     w_bcd_adj;
   logic                r_neg;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_digits;
   logic [4*DIGITS-1:0] w_digits;
   logic                r_ov;
   logic                w_ov;
   logic                r_done;
   logic                w_lead;
   logic                w_last_shift;

   assign w_last_shift = (r_cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SHIFT;
         S_SHIFT:  if (w_last_shift) w_next = S_FORMAT;
         S_FORMAT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Add-3 correction applied to every nibble before each shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < NB; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // Final formatting from the completed BCD accumulator.
   always_comb begin
      w_ov     = 1'b0;
      w_digits = '0;
      w_lead   = 1'b1;
      // Any nonzero nibble above the displayable magnitude digits is overflow.
      // With a sign, the most significant display digit is taken by the minus.
      for (int i = 0; i < NB; i++) begin
         if (r_bcd[4*i +: 4] != 4'd0) begin
            if (i >= DIGITS) w_ov = 1'b1;
            if (r_neg && (i == DIGITS - 1)) w_ov = 1'b1;
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         w_digits[4*i +: 4] = w_ov ? 4'd9 : r_bcd[4*i +: 4];
      end
      // Blank zeros above the highest nonzero digit; digit 0 always shows.
      if (!w_ov && (LZ_BLANK != 0)) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!(r_neg && (i == DIGITS - 1))) begin
               if (w_lead && (w_digits[4*i +: 4] == 4'd0)) w_digits[4*i +: 4] = BLANK4;
               else                                          w_lead = 1'b0;
            end
         end
      end
      if (r_neg) w_digits[4*(DIGITS-1) +: 4] = MINUS4;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg  <= '0;
         r_bcd    <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_digits <= {DIGITS{BLANK4}};
         r_ov     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shreg <= value;
                  r_neg   <= negative;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_SHIFT: begin
               // {bcd, shreg} shifts left by one after the add-3 step.
               r_bcd   <= {w_bcd_adj[4*NB-2:0], r_shreg[WIDTH-1]};
               r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
               r_cnt   <= r_cnt + CW'(1);
            end
            S_FORMAT: begin
               r_digits <= w_digits;
               r_ov     <= w_ov;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign overflow  = r_ov;
   assign digits    = r_digits;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_digits.sv
// Self-checking bench for bin_to_digits. Two instances share the inputs: one
// without and one with leading-zero blanking. A cycle-level reference model
// built on decimal arithmetic predicts busy/done/overflow/digits for both.
module tb_bin_to_digits;
   localparam int W = 32;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          negative = 1'b0;
   logic [W-1:0]  value = '0;

   logic          busy0, done0, ov0, busy1, done1, ov1;
   logic [4*D-1:0] dig0, dig1;
   logic [1:0]    st0, st1;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   // clock
   always #5 clk = ~clk;

   bin_to_digits #(.WIDTH(W), .DIGITS(D), .MINUS_CODE(10), .BLANK_CODE(11), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .value(value), .negative(negative),
      .busy(busy0), .done(done0), .overflow(ov0), .digits(dig0), .dbg_state(st0));

   bin_to_digits #(.WIDTH(W), .DIGITS(D), .MINUS_CODE(10), .BLANK_CODE(11), .LZ_BLANK(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .value(value), .negative(negative),
      .busy(busy1), .done(done1), .overflow(ov1), .digits(dig1), .dbg_state(st1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Decimal reference: returns {overflow, digits}.
   function automatic logic [4*D:0] model(input logic [W-1:0] v, input logic neg, input logic lz);
      logic [4*D-1:0] d;
      logic ov;
      longint x, p;
      int nmag;
      d = '0;
      nmag = neg ? D - 1 : D;
      p = 1;
      for (int i = 0; i < nmag; i++) p = p * 10;
      x = {32'd0, v};
      ov = (x >= p);
      for (int i = 0; i < nmag; i++) begin
         d[4*i +: 4] = ov ? 4'd9 : 4'(x % 10);
         x = x / 10;
      end
      if (lz && !ov) begin
         p = 10;
         for (int i = 1; i < nmag; i++) begin
            if ({32'd0, v} < p) d[4*i +: 4] = 4'd11;
            p = p * 10;
         end
      end
      if (neg) d[4*(D-1) +: 4] = 4'd10;
      return {ov, d};
   endfunction

   // Cycle-level model: busy for WIDTH+1 cycles after an accepted start, then done.
   int             m_cnt = 0;
   logic [W-1:0]   m_val;
   logic           m_neg;
   logic           m_done = 1'b0;
   logic [4*D:0]   m_r0 = {1'b0, {D{4'd11}}};
   logic [4*D:0]   m_r1 = {1'b0, {D{4'd11}}};

   always @(posedge clk) begin
      if (rst) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_r0   <= {1'b0, {D{4'd11}}};
         m_r1   <= {1'b0, {D{4'd11}}};
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               m_cnt <= W + 1;
               m_val <= value;
               m_neg <= negative;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_r0   <= model(m_val, m_neg, 1'b0);
               m_r1   <= model(m_val, m_neg, 1'b1);
               m_done <= 1'b1;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy0", {31'd0, busy0}, {31'd0, m_cnt != 0});
         check("done0", {31'd0, done0}, {31'd0, m_done});
         check("ov0",   {31'd0, ov0},   {31'd0, m_r0[4*D]});
         check("dig0",  {16'd0, dig0},  {16'd0, m_r0[4*D-1:0]});
         check("busy1", {31'd0, busy1}, {31'd0, m_cnt != 0});
         check("done1", {31'd0, done1}, {31'd0, m_done});
         check("ov1",   {31'd0, ov1},   {31'd0, m_r1[4*D]});
         check("dig1",  {16'd0, dig1},  {16'd0, m_r1[4*D-1:0]});
      end
   end

   // Called at the negedge right after the start edge (cycle 1).
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done0 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("done_timeout", {31'd0, done0}, 32'd1);
   endtask

   task automatic run(input string name, input logic [W-1:0] v, input logic n,
                      input logic [15:0] e0, input logic e0ov,
                      input logic [15:0] e1, input logic e1ov);
      int lat;
      @(negedge clk);
      value = v; negative = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0; value = $urandom; negative = 1'($urandom_range(0, 1));
      wait_done(lat);
      check({name, "_lat"}, lat, 34);
      check({name, "_d0"}, {16'd0, dig0}, {16'd0, e0});
      check({name, "_o0"}, {31'd0, ov0}, {31'd0, e0ov});
      check({name, "_d1"}, {16'd0, dig1}, {16'd0, e1});
      check({name, "_o1"}, {31'd0, ov1}, {31'd0, e1ov});
   endtask

   initial begin
      int lat;
      logic seen;
      // reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      check("rst_ov",   {31'd0, ov0}, 32'd0);
      check("rst_dig",  {16'd0, dig0}, 32'hBBBB);

      // model pins
      check("model_1234", {15'd0, model(32'd1234, 1'b0, 1'b0)}, {15'd0, 1'b0, 16'h1234});
      check("model_57n",  {15'd0, model(32'd57, 1'b1, 1'b1)},   {15'd0, 1'b0, 16'hAB57});
      check("model_10k",  {15'd0, model(32'd10000, 1'b0, 1'b1)}, {15'd0, 1'b1, 16'h9999});
      check("model_0lz",  {15'd0, model(32'd0, 1'b0, 1'b1)},   {15'd0, 1'b0, 16'hBBB0});

      // directed conversions
      run("v1234",  32'd1234,     1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);
      run("v0",     32'd0,        1'b0, 16'h0000, 1'b0, 16'hBBB0, 1'b0);
      run("v9999",  32'd9999,     1'b0, 16'h9999, 1'b0, 16'h9999, 1'b0);
      run("v10000", 32'd10000,    1'b0, 16'h9999, 1'b1, 16'h9999, 1'b1);
      run("n57",    32'd57,       1'b1, 16'hA057, 1'b0, 16'hAB57, 1'b0);
      run("n1000",  32'd1000,     1'b1, 16'hA999, 1'b1, 16'hA999, 1'b1);
      run("n999",   32'd999,      1'b1, 16'hA999, 1'b0, 16'hA999, 1'b0);
      run("n0",     32'd0,        1'b1, 16'hA000, 1'b0, 16'hABB0, 1'b0);
      run("v5",     32'd5,        1'b0, 16'h0005, 1'b0, 16'hBBB5, 1'b0);
      run("v100",   32'd100,      1'b0, 16'h0100, 1'b0, 16'hB100, 1'b0);
      run("vmax",   32'hFFFFFFFF, 1'b0, 16'h9999, 1'b1, 16'h9999, 1'b1);

      // start while busy is ignored; start on the done cycle is accepted
      @(negedge clk);
      value = 32'd1234; negative = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      value = 32'd42; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 10;
      while (!done0 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("busy_start_lat", lat, 34);
      check("busy_start_dig", {16'd0, dig0}, 32'h1234);
      value = 32'd42; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      check("done_cycle_lat", lat, 34);
      check("done_cycle_dig0", {16'd0, dig0}, 32'h0042);
      check("done_cycle_dig1", {16'd0, dig1}, 32'hBB42);

      // reset mid-conversion aborts without done
      @(negedge clk);
      value = 32'd1234; negative = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_dig0", {16'd0, dig0}, 32'hBBBB);
      check("abort_dig1", {16'd0, dig1}, 32'hBBBB);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done0 || done1) seen = 1'b1;
      end
      check("abort_no_done", {31'd0, seen}, 32'd0);
      run("after_rst", 32'd1234, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);
      run("n7",        32'd7,    1'b1, 16'hA007, 1'b0, 16'hABB7, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
